// File: rtl/piece_engine.sv
// Active-tetromino engine: runs one queued move per transaction and owns pose, next/hold and spawn.
// Build option PIECE_WALL_KICK_EN adds x-1 / x+1 retries to rejected rotations.
package piece_pkg;
  typedef enum logic [3:0] {
    NONE, INIT, WAIT, LEFT, RIGHT, DOWN, DROP, ROTATE, ROTATE_REV, HOLD, BAR
  } state_type;
  typedef enum logic [2:0] {
    S_OFF, S_SPAWN, S_IDLE, S_CHECK, S_LOCK, S_BAR, S_HALT
  } fsm_type;
endpackage

module piece_engine
  import piece_pkg::*;
#(
  parameter logic signed [4:0] SPAWN_X = 5'sd3,
  parameter logic [4:0]        SPAWN_Y = 5'd0,
  parameter int                BOARD_H = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  state_type          control,
  output state_type          state,
  input  logic               start,
  input  logic               over,
  input  logic [31:0]        rng,
  output logic signed [4:0]  pos_x,
  output logic [4:0]         pos_y,
  output logic [1:0]         rot,
  output logic [2:0]         kind,
  output logic [2:0]         next_kind,
  output logic [3:0]         hold_kind,
  output logic               chk_req,
  output logic signed [4:0]  chk_x,
  output logic [4:0]         chk_y,
  output logic [1:0]         chk_rot,
  output logic [2:0]         chk_kind,
  input  logic               chk_ack,
  input  logic               chk_hit,
  output logic               lock_req,
  input  logic               lock_ack,
  output logic               bar_req,
  input  logic               bar_ack,
  output logic               top_out,
  output fsm_type            fsm_state
);
  localparam logic [4:0] ROW_LAST = 5'(BOARD_H - 1);

  // Handshakes: each *_req rises from a register and stays high until its *_ack is
  // seen on a clock edge with the req high; the req drops on that edge. Acks seen
  // while the matching req is low are ignored.
  logic signed [4:0] cand_x;
  logic [4:0]        cand_y;
  logic [1:0]        cand_rot;
  logic [2:0]        cand_kind;
  state_type         cmd;
  logic              hold_used;
  logic [2:0]        rng_kind;
  logic              unused_rng;
`ifdef PIECE_WALL_KICK_EN
  logic [1:0]        kick;
`endif

  assign rng_kind   = (rng[2:0] == 3'd7) ? 3'd0 : rng[2:0];
  assign unused_rng = ^rng[31:3];
  assign chk_x      = cand_x;
  assign chk_y      = cand_y;
  assign chk_rot    = cand_rot;
  assign chk_kind   = cand_kind;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_state <= S_OFF;
      state     <= NONE;
      pos_x     <= SPAWN_X;
      pos_y     <= SPAWN_Y;
      rot       <= 2'd0;
      kind      <= 3'd0;
      next_kind <= 3'd0;
      hold_kind <= 4'd0;
      hold_used <= 1'b0;
      chk_req   <= 1'b0;
      lock_req  <= 1'b0;
      bar_req   <= 1'b0;
      top_out   <= 1'b0;
      cand_x    <= SPAWN_X;
      cand_y    <= SPAWN_Y;
      cand_rot  <= 2'd0;
      cand_kind <= 3'd0;
      cmd       <= NONE;
`ifdef PIECE_WALL_KICK_EN
      kick      <= 2'd0;
`endif
    end else begin
      top_out <= 1'b0;
      if (over || !start) begin
        fsm_state <= S_OFF;
        state     <= NONE;
        chk_req   <= 1'b0;
        lock_req  <= 1'b0;
        bar_req   <= 1'b0;
      end else begin
        case (fsm_state)
          S_OFF: begin
            fsm_state <= S_SPAWN;
            state     <= INIT;
          end
          S_SPAWN: begin
            kind      <= next_kind;
            next_kind <= rng_kind;
            pos_x     <= SPAWN_X;
            pos_y     <= SPAWN_Y;
            rot       <= 2'd0;
            hold_used <= 1'b0;
            cand_x    <= SPAWN_X;
            cand_y    <= SPAWN_Y;
            cand_rot  <= 2'd0;
            cand_kind <= next_kind;
            cmd       <= INIT;
            fsm_state <= S_CHECK;
          end
          S_IDLE: begin
            cand_x    <= pos_x;
            cand_y    <= pos_y;
            cand_rot  <= rot;
            cand_kind <= kind;
            cmd       <= control;
`ifdef PIECE_WALL_KICK_EN
            kick      <= 2'd0;
`endif
            if (control inside {LEFT, RIGHT, DOWN, DROP, ROTATE, ROTATE_REV} ||
                (control == HOLD && !hold_used)) begin
              fsm_state <= S_CHECK;
              state     <= control;
            end else if (control == BAR) begin
              fsm_state <= S_BAR;
              state     <= BAR;
              bar_req   <= 1'b1;
            end
            case (control)
              LEFT:       cand_x   <= pos_x - 5'sd1;
              RIGHT:      cand_x   <= pos_x + 5'sd1;
              DOWN, DROP: cand_y   <= pos_y + 5'd1;
              ROTATE:     cand_rot <= rot + 2'd1;
              ROTATE_REV: cand_rot <= rot - 2'd1;
              HOLD: begin
                cand_x    <= SPAWN_X;
                cand_y    <= SPAWN_Y;
                cand_rot  <= 2'd0;
                cand_kind <= hold_kind[3] ? hold_kind[2:0] : next_kind;
              end
              default: ;
            endcase
          end
          S_CHECK: begin
            if (!chk_req) begin
              chk_req <= 1'b1;
            end else if (chk_ack) begin
              chk_req <= 1'b0;
              if (!chk_hit) begin
                pos_x <= cand_x;
                pos_y <= cand_y;
                rot   <= cand_rot;
                kind  <= cand_kind;
                if (cmd == HOLD) begin
                  hold_kind <= {1'b1, kind};
                  hold_used <= 1'b1;
                  if (!hold_kind[3]) next_kind <= rng_kind;
                end
                // A drop keeps falling one row per query until the board reports a hit.
                if (cmd == DROP) begin
                  cand_y <= cand_y + 5'd1;
                end else begin
                  fsm_state <= S_IDLE;
                  state     <= WAIT;
                end
              end else begin
                case (cmd)
                  INIT: begin
                    top_out   <= 1'b1;
                    fsm_state <= S_HALT;
                    state     <= NONE;
                  end
                  DOWN, DROP: begin
                    lock_req  <= 1'b1;
                    fsm_state <= S_LOCK;
                  end
                  BAR: begin
                    if (cand_y != 5'd0) begin
                      cand_y <= cand_y - 5'd1;
                    end else begin
                      top_out   <= 1'b1;
                      fsm_state <= S_HALT;
                      state     <= NONE;
                    end
                  end
`ifdef PIECE_WALL_KICK_EN
                  ROTATE, ROTATE_REV: begin
                    if (kick == 2'd0) begin
                      cand_x <= pos_x - 5'sd1;
                      kick   <= 2'd1;
                    end else if (kick == 2'd1) begin
                      cand_x <= pos_x + 5'sd1;
                      kick   <= 2'd2;
                    end else begin
                      fsm_state <= S_IDLE;
                      state     <= WAIT;
                    end
                  end
`endif
                  default: begin
                    fsm_state <= S_IDLE;
                    state     <= WAIT;
                  end
                endcase
              end
            end
          end
          S_LOCK: begin
            if (lock_ack) begin
              lock_req  <= 1'b0;
              fsm_state <= S_SPAWN;
              state     <= INIT;
            end
          end
          S_BAR: begin
            if (bar_ack) begin
              bar_req   <= 1'b0;
              fsm_state <= S_CHECK;
            end
          end
          S_HALT: state <= NONE;
          default: fsm_state <= S_OFF;
        endcase
      end
    end
  end

  // The board reports floor hits, so a settled piece never sits below the last row.
  assert property (@(posedge clk) disable iff (!reset_n) pos_y <= ROW_LAST);
endmodule
